// File: rtl/vic_pkg.sv
// Shared definitions for the VIC-20 video chip register file: register
// indices, reset values and the VIC-to-CPU address translation.
package vic_pkg;

   localparam logic [3:0] REG_HORIG  = 4'h0;
   localparam logic [3:0] REG_VORIG  = 4'h1;
   localparam logic [3:0] REG_COLS   = 4'h2;
   localparam logic [3:0] REG_ROWS   = 4'h3;
   localparam logic [3:0] REG_RASTER = 4'h4;
   localparam logic [3:0] REG_BASE   = 4'h5;
   localparam logic [3:0] REG_LPENX  = 4'h6;
   localparam logic [3:0] REG_LPENY  = 4'h7;
   localparam logic [3:0] REG_POTX   = 4'h8;
   localparam logic [3:0] REG_POTY   = 4'h9;
   localparam logic [3:0] REG_VOICE0 = 4'hA;
   localparam logic [3:0] REG_VOICE1 = 4'hB;
   localparam logic [3:0] REG_VOICE2 = 4'hC;
   localparam logic [3:0] REG_VOICE3 = 4'hD;
   localparam logic [3:0] REG_VOLUME = 4'hE;
   localparam logic [3:0] REG_COLOR  = 4'hF;

   localparam logic [7:0] RST_HORIG  = 8'h0C;
   localparam logic [7:0] RST_VORIG  = 8'h26;
   localparam logic [7:0] RST_COLS   = 8'h96;
   localparam logic [7:0] RST_ROWS   = 8'h2E;
   localparam logic [7:0] RST_BASE   = 8'hF0;
   localparam logic [7:0] RST_COLOR  = 8'h1B;
   localparam logic [7:0] RST_AUDIO  = 8'h00;

   // Frame-buffered video configuration; rows keeps only the 7 stored bits.
   typedef struct packed {
      logic [7:0] horig;
      logic [7:0] vorig;
      logic [7:0] cols;
      logic [6:0] rows;
      logic [7:0] base;
      logic [7:0] color;
   } video_regs_t;

   localparam video_regs_t VIDEO_RST = '{
      horig: RST_HORIG,
      vorig: RST_VORIG,
      cols:  RST_COLS,
      rows:  RST_ROWS[6:0],
      base:  RST_BASE,
      color: RST_COLOR
   };

   function automatic logic is_video_reg(input logic [3:0] a);
      return a inside {REG_HORIG, REG_VORIG, REG_COLS, REG_ROWS, REG_BASE, REG_COLOR};
   endfunction

   // VA13 selects between the block at $0000 (VA13=1) and $8000 (VA13=0).
   function automatic logic [15:0] va_to_cpu(input logic [13:0] va);
      return {~va[13], 2'b00, va[12:0]};
   endfunction

endpackage

// File: rtl/vic_regs_if.sv
// CPU-side register bus of the VIC: select, direction, index and data.
interface vic_regs_if;
   logic       cs;
   logic       we;
   logic [3:0] addr;
   logic [7:0] din;
   logic [7:0] dout;

   modport master (output cs, output we, output addr, output din, input dout);
   modport slave  (input cs, input we, input addr, input din, output dout);
endinterface

// File: rtl/vic_frame_commit.sv
// Decides when shadow video registers are copied to live: at frame start
// with a write pending, or one cycle after each write when unsynchronised.
module vic_frame_commit #(
   parameter bit SYNC_COMMIT = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] raster_line,
   input  logic       video_wr,
   output logic       load,
   output logic       commit
);

   logic [7:0] prev_raster;
   logic       pending;
   logic       frame_start;

   always_comb begin
      frame_start = (raster_line == 8'd0) && (prev_raster != 8'd0);
      if (SYNC_COMMIT)
         load = frame_start && pending;
      else
         load = pending;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prev_raster <= 8'd0;
         pending     <= 1'b0;
         commit      <= 1'b0;
      end else begin
         prev_raster <= raster_line;
         commit      <= load;
         // A write on the commit edge stays pending for the next frame.
         if (load)
            pending <= video_wr;
         else if (video_wr)
            pending <= 1'b1;
      end
   end

endmodule

// File: rtl/vic_regs.sv
// VIC-20 register file ($9000-$900F): shadow/live video registers,
// unbuffered audio registers, registered read port and address outputs.
module vic_regs
   import vic_pkg::*;
#(
   parameter bit SYNC_COMMIT = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   vic_regs_if.slave   bus,
   input  logic [7:0]  raster_line,
   input  logic [7:0]  pot_x,
   input  logic [7:0]  pot_y,
   input  logic [7:0]  lpen_x,
   input  logic [7:0]  lpen_y,
   output logic [15:0] screen_addr,
   output logic [15:0] char_rom_addr,
   output logic [15:0] color_ram_addr,
   output logic [2:0]  border_color,
   output logic [3:0]  back_color,
   output logic [3:0]  aux_color,
   output logic        inverted,
   output logic        chars8x16,
   output logic        interlace,
   output logic [6:0]  xorigin,
   output logic [7:0]  yorigin,
   output logic [6:0]  rows,
   output logic [6:0]  cols,
   output logic [7:0]  voice0,
   output logic [7:0]  voice1,
   output logic [7:0]  voice2,
   output logic [7:0]  voice3,
   output logic [3:0]  volume,
   output logic        commit
);

   video_regs_t shadow;
   video_regs_t live;
   logic [7:0]  audio_ctl;
   logic [7:0]  rd_data;
   logic        bus_wr;
   logic        bus_rd;
   logic        video_wr;
   logic        load;

   assign bus_wr   = bus.cs && bus.we;
   assign bus_rd   = bus.cs && !bus.we;
   assign video_wr = bus_wr && is_video_reg(bus.addr);

   vic_frame_commit #(.SYNC_COMMIT(SYNC_COMMIT)) u_commit (
      .clk         (clk),
      .reset       (reset),
      .raster_line (raster_line),
      .video_wr    (video_wr),
      .load        (load),
      .commit      (commit)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shadow <= VIDEO_RST;
      end else if (video_wr) begin
         case (bus.addr)
            REG_HORIG: shadow.horig <= bus.din;
            REG_VORIG: shadow.vorig <= bus.din;
            REG_COLS:  shadow.cols  <= bus.din;
            REG_ROWS:  shadow.rows  <= bus.din[6:0];
            REG_BASE:  shadow.base  <= bus.din;
            REG_COLOR: shadow.color <= bus.din;
            default: ;
         endcase
      end
   end

   // NOTE: non-blocking assignment means live samples shadow as it was before
   // this edge, so a write landing on the commit edge waits for the next frame.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         live <= VIDEO_RST;
      else if (load)
         live <= shadow;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         voice0    <= RST_AUDIO;
         voice1    <= RST_AUDIO;
         voice2    <= RST_AUDIO;
         voice3    <= RST_AUDIO;
         audio_ctl <= RST_AUDIO;
      end else if (bus_wr) begin
         case (bus.addr)
            REG_VOICE0: voice0    <= bus.din;
            REG_VOICE1: voice1    <= bus.din;
            REG_VOICE2: voice2    <= bus.din;
            REG_VOICE3: voice3    <= bus.din;
            REG_VOLUME: audio_ctl <= bus.din;
            default: ;
         endcase
      end
   end

   // NOTE: rd_data gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      rd_data = 8'h00;
      case (bus.addr)
         REG_HORIG:  rd_data = shadow.horig;
         REG_VORIG:  rd_data = shadow.vorig;
         REG_COLS:   rd_data = shadow.cols;
         REG_ROWS:   rd_data = {1'b0, shadow.rows};
         REG_RASTER: rd_data = raster_line;
         REG_BASE:   rd_data = shadow.base;
         REG_LPENX:  rd_data = lpen_x;
         REG_LPENY:  rd_data = lpen_y;
         REG_POTX:   rd_data = pot_x;
         REG_POTY:   rd_data = pot_y;
         REG_VOICE0: rd_data = voice0;
         REG_VOICE1: rd_data = voice1;
         REG_VOICE2: rd_data = voice2;
         REG_VOICE3: rd_data = voice3;
         REG_VOLUME: rd_data = audio_ctl;
         REG_COLOR:  rd_data = shadow.color;
         default:    rd_data = 8'h00;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         bus.dout <= 8'h00;
      else if (bus_rd)
         bus.dout <= rd_data;
   end

   assign interlace      = live.horig[7];
   assign xorigin        = live.horig[6:0];
   assign yorigin        = live.vorig;
   assign cols           = live.cols[6:0];
   assign rows           = {1'b0, live.rows[6:1]};
   assign chars8x16      = live.rows[0];
   assign back_color     = live.color[7:4];
   assign inverted       = live.color[3];
   assign border_color   = live.color[2:0];
   assign aux_color      = audio_ctl[7:4];
   assign volume         = audio_ctl[3:0];

   // live.cols[7] is VA9 for both screen memory and colour RAM.
   assign screen_addr    = va_to_cpu({live.base[7:4], live.cols[7], 9'b0});
   assign char_rom_addr  = va_to_cpu({live.base[3:0], 10'b0});
   assign color_ram_addr = 16'h9400 | {6'b0, live.cols[7], 9'b0};

endmodule
